// File: rtl/charlieplex_pkg.sv
// Shared definitions for charlieplexed LED drivers: scan phase type and
// sizing helpers that derive LED count and index width from the pin count.
package charlieplex_pkg;

  // Scan phase within one LED slot.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_LIT   = 1'b1
  } phase_t;

  // Number of LEDs addressable with a given number of charlieplex pins.
  function automatic int ledcount(input int pincount);
    return pincount * (pincount - 1);
  endfunction

  // Width of an LED index for a given pin count (at least one bit).
  function automatic int indexbits(input int pincount);
    int n;
    n = ledcount(pincount);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/charlieplex_slot_timer.sv
// Slot timer for the charlieplex scanner. Counts the cycles of one LED slot
// (BLANK dark cycles followed by DWELL lit cycles) and tracks the phase as a
// two-state machine. Reports the phase of the coming cycle, the last cycle
// of the slot, and the last cycle of the frame (slot end on the final LED).
module charlieplex_slot_timer
  import charlieplex_pkg::*;
#(
  parameter int LEDCOUNT  = 12,
  parameter int INDEXBITS = 4,
  parameter int DWELL     = 64,
  parameter int BLANK     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEXBITS-1:0] led_index,
  output phase_t               phase_next,
  output logic                 slot_end,
  output logic                 frame_wrap
);

  localparam int SLOT = BLANK + DWELL;
  localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;

  localparam logic [CW-1:0]        BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0]        SLOT_LAST  = CW'(SLOT - 1);
  localparam logic [INDEXBITS-1:0] LED_LAST   = INDEXBITS'(LEDCOUNT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  phase_t        phase;

  // Next-state decode: BLANK hands over to LIT after the last dark cycle,
  // LIT returns to BLANK and restarts the count at the end of the slot.
  always_comb begin
    cnt_next   = cnt + CW'(1);
    phase_next = phase;
    slot_end   = 1'b0;
    unique case (phase)
      PH_BLANK: begin
        if (cnt == BLANK_LAST) begin
          phase_next = PH_LIT;
        end
      end
      PH_LIT: begin
        if (cnt == SLOT_LAST) begin
          slot_end   = 1'b1;
          cnt_next   = '0;
          phase_next = PH_BLANK;
        end
      end
      default: begin
        phase_next = PH_BLANK;
      end
    endcase
  end

  assign frame_wrap = slot_end && (led_index == LED_LAST);

  // Slot counter and phase register; reset aborts the current slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= PH_BLANK;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/charlieplex_scanner.sv
// Charlieplex scanner: steps through every LED index in fixed-length slots
// and lights the selected LED during the lit part of its slot when the
// active frame bit is set. New frames are taken into a pending buffer via a
// valid/ready handshake and promoted to the active frame only at frame wrap,
// so a frame is never torn mid-scan. All outputs are registered; their next
// values are computed from the next-cycle state so that each output cycle
// reflects the slot position of that same cycle.
module charlieplex_scanner
  import charlieplex_pkg::*;
#(
  parameter int PINCOUNT = 4,
  parameter int DWELL    = 64,
  parameter int BLANK    = 2,
  localparam int LEDCOUNT  = ledcount(PINCOUNT),
  localparam int INDEXBITS = indexbits(PINCOUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [LEDCOUNT-1:0]  frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [INDEXBITS-1:0] led_index,
  output logic                 led_enable,
  output logic                 frame_done
);

  phase_t              phase_next;
  logic                slot_end;
  logic                frame_wrap;

  logic [LEDCOUNT-1:0] active;
  logic [LEDCOUNT-1:0] active_next;
  logic [LEDCOUNT-1:0] pending;
  logic                accept;
  logic                swap;
  logic [INDEXBITS-1:0] index_next;

  charlieplex_slot_timer #(
    .LEDCOUNT  (LEDCOUNT),
    .INDEXBITS (INDEXBITS),
    .DWELL     (DWELL),
    .BLANK     (BLANK)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .led_index  (led_index),
    .phase_next (phase_next),
    .slot_end   (slot_end),
    .frame_wrap (frame_wrap)
  );

  // Next index and next active frame. Accept and swap are mutually
  // exclusive: accepting needs an empty pending buffer, swapping a full one.
  always_comb begin
    accept      = frame_valid && frame_ready;
    swap        = frame_wrap && !frame_ready;
    active_next = active;
    index_next  = led_index;
    if (swap) begin
      active_next = pending;
    end
    if (slot_end) begin
      index_next = frame_wrap ? '0 : led_index + INDEXBITS'(1);
    end
  end

  // Control and output registers: index, active frame, handshake flag and
  // the registered LED drive, frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_index   <= '0;
      led_enable  <= 1'b0;
      frame_done  <= 1'b0;
      frame_ready <= 1'b1;
      active      <= '0;
    end else begin
      led_index   <= index_next;
      active      <= active_next;
      led_enable  <= (phase_next == PH_LIT) && active_next[index_next] && enable;
      frame_done  <= frame_wrap;
      if (accept) begin
        frame_ready <= 1'b0;
      end else if (swap) begin
        frame_ready <= 1'b1;
      end
    end
  end

  // Pending frame storage; its contents only matter while frame_ready is low.
  always_ff @(posedge clk) begin
    if (accept) begin
      pending <= frame_in;
    end
  end

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Bench for charlieplex_scanner with PINCOUNT=3, DWELL=4, BLANK=2.
// A time-based reference (cycles since reset, modulo the frame period)
// predicts every output each cycle through a scoreboard queue, and a table
// of stimulus segments carries hand-derived lit-cycle totals and the
// expected frame_ready at the end of each segment.
module tb_charlieplex_scanner;
  import charlieplex_pkg::*;

  localparam int PINCOUNT = 3;
  localparam int DWELL    = 4;
  localparam int BLANK    = 2;
  localparam int NLED     = ledcount(PINCOUNT);
  localparam int IW       = indexbits(PINCOUNT);
  localparam int SLOT     = BLANK + DWELL;
  localparam int FRAME    = NLED * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [NLED-1:0] frame_in = '0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [IW-1:0] led_index;
  logic          led_enable;
  logic          frame_done;

  charlieplex_scanner #(
    .PINCOUNT (PINCOUNT),
    .DWELL    (DWELL),
    .BLANK    (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .led_index   (led_index),
    .led_enable  (led_enable),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic          en;
    logic          done;
    logic          ready;
  } exp_t;

  typedef struct {
    logic          r;
    logic          en;
    logic          v;
    logic [NLED-1:0] f;
    int            n;
    int            lit;
    logic          rdy;
  } row_t;

  exp_t sb[$];
  row_t tbl[20];

  int checks = 0;
  int errors = 0;

  int              m_t = 0;
  logic [NLED-1:0] m_active = '0;
  logic [NLED-1:0] m_pend = '0;
  logic            m_full = 1'b0;

  logic [IW-1:0] prev_idx;
  bit            have_prev = 1'b0;
  int            lit_cnt;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  // Reference: predict the outputs visible after the coming clock edge.
  task automatic model_edge(input logic r, input logic en, input logic [NLED-1:0] f,
                            input logic v);
    exp_t e;
    bit   wrap;
    bit   acc;
    int   slot;
    if (r) begin
      m_t      = 0;
      m_active = '0;
      m_full   = 1'b0;
      e.idx    = '0;
      e.en     = 1'b0;
      e.done   = 1'b0;
      e.ready  = 1'b1;
    end else begin
      wrap = (m_t == FRAME - 1);
      acc  = v && !m_full;
      if (wrap && m_full) begin
        m_active = m_pend;
        m_full   = 1'b0;
      end
      if (acc) begin
        m_pend = f;
        m_full = 1'b1;
      end
      m_t    = (m_t + 1) % FRAME;
      slot   = m_t / SLOT;
      e.idx  = IW'(slot);
      e.done = wrap;
      e.en   = ((m_t % SLOT) >= BLANK) && m_active[slot] && en;
      e.ready = !m_full;
    end
    sb.push_back(e);
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input logic r, input logic en, input logic [NLED-1:0] f,
                       input logic v);
    exp_t e;
    @(negedge clk);
    rst = r;
    enable = en;
    frame_in = f;
    frame_valid = v;
    model_edge(r, en, f, v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("led_index", int'(led_index), int'(e.idx));
      check("led_enable", int'(led_enable), int'(e.en));
      check("frame_done", int'(frame_done), int'(e.done));
      check("frame_ready", int'(frame_ready), int'(e.ready));
    end
    check("index_range", int'(led_index < IW'(NLED)), 1);
    if (have_prev && (led_index != prev_idx)) begin
      check("dark_at_index_change", int'(led_enable), 0);
    end
    prev_idx  = led_index;
    have_prev = !r;
    if (led_enable) lit_cnt++;
  endtask

  initial begin
    //            rst   en    valid frame      n   lit  ready_end
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'b000000,  2,  0, 1'b1};  // reset
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 70,  0, 1'b1};  // idle scan, dark
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 6'b000101,  1,  0, 1'b0};  // offer 000101
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 6'b000000, 73, 16, 1'b1};  // two frames of 000101
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 6'b111111,  1,  0, 1'b0};  // A
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 6'b000010, 36,  8, 1'b0};  // B held until taken
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 6'b000000, 71, 28, 1'b1};  // A frame then B frame
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 6'b111111,  1,  0, 1'b0};  // C all ones
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 6'b000000, 56, 18, 1'b1};  // into slot 3 lit phase
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 15,  0, 1'b1};  // enable dropped
    tbl[10] = '{1'b0, 1'b1, 1'b0, 6'b000000, 36, 24, 1'b1};  // full frame all ones
    tbl[11] = '{1'b0, 1'b1, 1'b1, 6'b000001,  1,  0, 1'b0};  // D pending
    tbl[12] = '{1'b0, 1'b1, 1'b0, 6'b000000, 26, 18, 1'b0};  // into slot 4 lit phase
    tbl[13] = '{1'b1, 1'b1, 1'b0, 6'b000000,  1,  0, 1'b1};  // reset drops D
    tbl[14] = '{1'b0, 1'b1, 1'b0, 6'b000000, 80,  0, 1'b1};  // dark after reset
    tbl[15] = '{1'b0, 1'b1, 1'b1, 6'b100000,  1,  0, 1'b0};  // E
    tbl[16] = '{1'b0, 1'b1, 1'b0, 6'b000000, 63,  4, 1'b1};  // E frame
    tbl[17] = '{1'b0, 1'b1, 1'b0, 6'b000000, 35,  4, 1'b1};  // up to wrap cycle
    tbl[18] = '{1'b0, 1'b1, 1'b1, 6'b001000,  1,  0, 1'b0};  // F taken on wrap
    tbl[19] = '{1'b0, 1'b1, 1'b0, 6'b000000, 72,  8, 1'b1};  // E again, then F

    for (int i = 0; i < 20; i++) begin
      lit_cnt = 0;
      for (int k = 0; k < tbl[i].n; k++) begin
        cycle(tbl[i].r, tbl[i].en, tbl[i].f, tbl[i].v);
      end
      check($sformatf("row%0d_lit_cycles", i), lit_cnt, tbl[i].lit);
      check($sformatf("row%0d_ready_end", i), int'(frame_ready), int'(tbl[i].rdy));
    end

    // Reset asserted together with a valid offer: the offer must not survive.
    cycle(1'b1, 1'b1, 6'b111111, 1'b1);
    check("reset_with_offer_ready", int'(frame_ready), 1);
    check("reset_with_offer_index", int'(led_index), 0);
    lit_cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle(1'b0, 1'b1, 6'b000000, 1'b0);
    end
    check("reset_with_offer_dark", lit_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
